// File: rtl/transpose_buffer_11x8.sv
// Row-in, column-out transpose buffer: collects 11 rows of 8 samples, then holds
// the block as 8 columns of 11 samples until downstream releases it.
module transpose_buffer_11x8 #(
   parameter int SAMPLE_W = 9,
   parameter int ROWS     = 11,
   parameter int COLS     = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [COLS*SAMPLE_W-1:0]     row_in,
   input  logic                         row_valid,
   output logic                         row_ready,
   input  logic                         flush,
   input  logic                         block_release,
   output logic                         block_valid,
   output logic [ROWS*SAMPLE_W-1:0]     column_0,
   output logic [ROWS*SAMPLE_W-1:0]     column_1,
   output logic [ROWS*SAMPLE_W-1:0]     column_2,
   output logic [ROWS*SAMPLE_W-1:0]     column_3,
   output logic [ROWS*SAMPLE_W-1:0]     column_4,
   output logic [ROWS*SAMPLE_W-1:0]     column_5,
   output logic [ROWS*SAMPLE_W-1:0]     column_6,
   output logic [ROWS*SAMPLE_W-1:0]     column_7,
   output logic [3:0]                   row_count
);

   localparam logic [3:0] LAST_ROW   = 4'(ROWS - 1);
   localparam logic [3:0] FULL_COUNT = 4'(ROWS);

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t                      state_reg;
   logic [3:0]                  row_count_reg;
   logic                        row_ready_reg;
   logic                        block_valid_reg;
   logic [COLS*SAMPLE_W-1:0]    mem_reg [ROWS];
   logic                        wr_en;
   logic [COLS-1:0][ROWS*SAMPLE_W-1:0] col_w;

   // Flush beats a simultaneous accept, so it masks the write.
   assign wr_en = (state_reg == FILL) && row_valid && !flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= FILL;
         row_count_reg   <= '0;
         row_ready_reg   <= 1'b1;
         block_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            FILL: begin
               if (flush) begin
                  row_count_reg <= '0;
               end else if (row_valid) begin
                  if (row_count_reg == LAST_ROW) begin
                     row_count_reg   <= FULL_COUNT;
                     state_reg       <= FULL;
                     row_ready_reg   <= 1'b0;
                     block_valid_reg <= 1'b1;
                  end else begin
                     row_count_reg <= row_count_reg + 4'd1;
                  end
               end
            end
            FULL: begin
               if (block_release) begin
                  row_count_reg   <= '0;
                  state_reg       <= FILL;
                  row_ready_reg   <= 1'b1;
                  block_valid_reg <= 1'b0;
               end
            end
            default: state_reg <= FILL;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < ROWS; r++) begin
            mem_reg[r] <= '0;
         end
      end else begin
         for (int r = 0; r < ROWS; r++) begin
            if (wr_en && row_count_reg == 4'(r)) begin
               mem_reg[r] <= row_in;
            end
         end
      end
   end

   // Pure rewiring: sample c of row r lands in field r of column c.
   for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      for (genvar gj = 0; gj < COLS; gj++) begin : g_col
         assign col_w[gj][gi*SAMPLE_W +: SAMPLE_W] = mem_reg[gi][gj*SAMPLE_W +: SAMPLE_W];
      end
   end

   assign column_0    = col_w[0];
   assign column_1    = col_w[1];
   assign column_2    = col_w[2];
   assign column_3    = col_w[3];
   assign column_4    = col_w[4];
   assign column_5    = col_w[5];
   assign column_6    = col_w[6];
   assign column_7    = col_w[7];
   assign row_count   = row_count_reg;
   assign row_ready   = row_ready_reg;
   assign block_valid = block_valid_reg;

endmodule

// File: tb/tb_transpose_buffer_11x8.sv
// Self-checking bench for transpose_buffer_11x8: control-vector table, a reference
// model feeding a block scoreboard, and hand-written corner-case sequences.
module tb_transpose_buffer_11x8;

   typedef logic [7:0][98:0] blk_t;

   typedef struct {
      logic       rst;
      logic       valid;
      logic       flush;
      logic       rel;
      logic [3:0] exp_count;
      logic       exp_bv;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [71:0] row_in = '0;
   logic        row_valid = 1'b0;
   logic        row_ready;
   logic        flush = 1'b0;
   logic        block_release = 1'b0;
   logic        block_valid;
   logic [98:0] column_0, column_1, column_2, column_3;
   logic [98:0] column_4, column_5, column_6, column_7;
   logic [3:0]  row_count;

   transpose_buffer_11x8 dut (
      .clk          (clk),
      .rst          (rst),
      .row_in       (row_in),
      .row_valid    (row_valid),
      .row_ready    (row_ready),
      .flush        (flush),
      .block_release(block_release),
      .block_valid  (block_valid),
      .column_0     (column_0),
      .column_1     (column_1),
      .column_2     (column_2),
      .column_3     (column_3),
      .column_4     (column_4),
      .column_5     (column_5),
      .column_6     (column_6),
      .column_7     (column_7),
      .row_count    (row_count)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [71:0] m_mem [11];
   int          m_count = 0;
   bit          m_full = 1'b0;
   blk_t        sb_q[$];
   blk_t        held;
   bit          prev_bv = 1'b0;
   vec_t        vt [10];

   task automatic chk(input string name, input logic [98:0] act, input logic [98:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic blk_t dut_block();
      blk_t b;
      b[0] = column_0; b[1] = column_1; b[2] = column_2; b[3] = column_3;
      b[4] = column_4; b[5] = column_5; b[6] = column_6; b[7] = column_7;
      return b;
   endfunction

   function automatic blk_t model_block();
      blk_t b;
      for (int c = 0; c < 8; c++)
         for (int r = 0; r < 11; r++)
            b[c][r*9 +: 9] = m_mem[r][c*9 +: 9];
      return b;
   endfunction

   function automatic logic [71:0] grid_row(input int r);
      logic [71:0] v;
      for (int c = 0; c < 8; c++) v[c*9 +: 9] = 9'(16*r + c);
      return v;
   endfunction

   function automatic logic [71:0] rand_row();
      return {$urandom, $urandom, 8'($urandom)};
   endfunction

   task automatic cmp_block(input string tag, input blk_t exp);
      blk_t act;
      act = dut_block();
      for (int c = 0; c < 8; c++)
         chk($sformatf("%s_col%0d", tag, c), act[c], exp[c]);
   endtask

   // Drive one cycle, advance the reference model, then check after the edge.
   task automatic step(input logic r, input logic v, input logic f, input logic rl,
                       input logic [71:0] row);
      rst = r; row_valid = v; flush = f; block_release = rl; row_in = row;
      if (r) begin
         for (int i = 0; i < 11; i++) m_mem[i] = '0;
         m_count = 0;
         m_full  = 1'b0;
      end else if (!m_full) begin
         if (f) begin
            m_count = 0;
         end else if (v) begin
            m_mem[m_count] = row;
            if (m_count == 10) begin
               m_count = 11;
               m_full  = 1'b1;
               sb_q.push_back(model_block());
            end else begin
               m_count++;
            end
         end
      end else if (rl) begin
         m_full  = 1'b0;
         m_count = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
      $display("[TB] cyc %0d rst=%0b v=%0b fl=%0b rel=%0b -> count=%0d ready=%0b bv=%0b",
               cyc, r, v, f, rl, row_count, row_ready, block_valid);
      chk("row_count", 99'(row_count), 99'(m_count));
      chk("row_ready", 99'(row_ready), 99'(!m_full));
      chk("block_valid", 99'(block_valid), 99'(m_full));
      if (block_valid && !prev_bv) begin
         tests++;
         if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected_block: got block_valid 1 expected no block");
         end else begin
            held = sb_q.pop_front();
            cmp_block("sb", held);
         end
      end else if (block_valid) begin
         cmp_block("hold", held);
      end
      prev_bv = block_valid;
      rst = 1'b0; row_valid = 1'b0; flush = 1'b0; block_release = 1'b0;
   endtask

   initial begin
      int acc;
      logic [3:0] last_cnt;

      for (int i = 0; i < 11; i++) m_mem[i] = '0;
      //              rst   valid flush rel   count bv
      vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
      vt[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0};
      vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0};
      vt[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0};
      vt[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0};
      vt[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0};
      vt[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0};
      vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0};
      vt[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
      vt[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0};

      for (int i = 0; i < 10; i++) begin
         step(vt[i].rst, vt[i].valid, vt[i].flush, vt[i].rel, rand_row());
         chk($sformatf("tbl%0d_count", i), 99'(row_count), 99'(vt[i].exp_count));
         chk($sformatf("tbl%0d_bv", i), 99'(block_valid), 99'(vt[i].exp_bv));
      end

      // Reset idle state: array cleared, all columns zero.
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      cmp_block("reset", '0);

      // Back-to-back 16r+c block.
      for (int r = 0; r < 11; r++) step(1'b0, 1'b1, 1'b0, 1'b0, grid_row(r));
      chk("grid_bv", 99'(block_valid), 99'(1));
      for (int r = 0; r < 11; r++)
         chk($sformatf("grid_col3_r%0d", r), 99'(column_3[r*9 +: 9]), 99'(16*r + 3));
      chk("grid_col5_top", 99'(column_5[98:90]), 99'(165));

      // Hold with ROW_VALID and a FLUSH attempt, then release.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, (i == 2), 1'b0, rand_row());
      chk("hold_ready", 99'(row_ready), 99'(0));
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      chk("rel_ready", 99'(row_ready), 99'(1));
      chk("rel_count", 99'(row_count), 99'(0));

      // Partial fill, flush colliding with a valid row.
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 1'b0, rand_row());
      step(1'b0, 1'b1, 1'b1, 1'b0, {72{1'b1}});
      chk("flush_count", 99'(row_count), 99'(0));
      cmp_block("flush_nowrite", model_block());
      for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, 1'b0, {72{1'b1}});
      chk("ones_col0", column_0, {99{1'b1}});
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);

      // 1-of-3 valid duty cycle.
      acc = 0;
      last_cnt = row_count;
      for (int i = 0; i < 33; i++) begin
         step(1'b0, (i % 3 == 0), 1'b0, 1'b0, rand_row());
         if (row_count != last_cnt && !(row_count == 4'd0)) acc++;
         last_cnt = row_count;
      end
      chk("gap_accepts", 99'(acc), 99'(11));
      chk("gap_bv", 99'(block_valid), 99'(1));
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);

      // Reset mid-fill, reset while full, reset colliding with the 11th accept.
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0, rand_row());
      chk("pre_rst_count", 99'(row_count), 99'(7));
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      chk("rst_fill_col0", column_0, '0);
      for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, 1'b0, rand_row());
      step(1'b1, 1'b1, 1'b0, 1'b0, rand_row());
      chk("rst_full_bv", 99'(block_valid), 99'(0));
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, rand_row());
      step(1'b1, 1'b1, 1'b0, 1'b0, rand_row());
      chk("rst_11th_bv", 99'(block_valid), 99'(0));
      chk("rst_11th_count", 99'(row_count), 99'(0));
      for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 1'b0, 1'b0, rand_row());
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);

      chk("sb_drained", 99'(sb_q.size()), 99'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
